// File: rtl/shift_sequencer_if.sv
// Request/response bundle between a shift requester and the shift sequencer.
// The requester drives the operand and START; the sequencer returns BUSY,
// a one-cycle DONE pulse and the held RESULT.
interface shift_sequencer_if #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 5
);
   logic             start;
   logic             dir;      // 1 = right, 0 = left
   logic             arith;    // sign-fill on right shifts
   logic [AMT_W-1:0] amt;
   logic [WIDTH-1:0] data_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, dir, arith, amt, data_in,
      input  busy, done, result
   );

   modport slave (
      input  start, dir, arith, amt, data_in,
      output busy, done, result
   );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shift controller wrapped around an external 4-bit
// shifter stage. The accumulator is fed through the stage once per cycle for
// each 4-bit step, then the 0..3 remaining positions are done internally
// one bit per cycle. RESULT/DONE are registered out of the FINISH state.
module shift_sequencer #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 5
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   shift_sequencer_if.slave s_if,
   output logic             o_stg_sh_dir,
   output logic             o_stg_amt_n,
   output logic             o_stg_neg,
   output logic [WIDTH-1:0] o_stg_in,
   input  logic [WIDTH-1:0] i_stg_out
);

   localparam int CNT4_W = AMT_W - 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT4 = 2'd1,
      ST_SHIFT1 = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [WIDTH-1:0]    r_acc;
   logic [CNT4_W-1:0]   r_cnt4;
   logic [1:0]          r_cnt1;
   logic                r_dir;
   logic                r_fill;
   logic [WIDTH-1:0]    r_result;
   logic                r_done;

   logic                w_capture;
   logic [CNT4_W-1:0]   w_amt4;
   logic [1:0]          w_amt1;
   logic [WIDTH-1:0]    w_shift1;

   assign w_amt4 = s_if.amt[AMT_W-1:2];
   assign w_amt1 = s_if.amt[1:0];

   // DONE rises in the cycle after FINISH, when the FSM is already back in
   // IDLE. That cycle still counts as busy so a START coinciding with the
   // DONE pulse is dropped instead of silently starting a new operation.
   assign w_capture = (r_state == ST_IDLE) && !r_done && s_if.start;

   // One-bit step: right shifts insert the latched fill, left shifts insert 0.
   assign w_shift1 = r_dir ? {r_fill, r_acc[WIDTH-1:1]}
                           : {r_acc[WIDTH-2:0], 1'b0};

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; the last step of each phase picks the following phase
   // so no cycle is wasted on a zero count.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_capture) begin
               if (w_amt4 != '0)      w_next_state = ST_SHIFT4;
               else if (w_amt1 != '0) w_next_state = ST_SHIFT1;
               else                   w_next_state = ST_FINISH;
            end
         end
         ST_SHIFT4: begin
            if (r_cnt4 == CNT4_W'(1)) begin
               if (r_cnt1 != '0) w_next_state = ST_SHIFT1;
               else              w_next_state = ST_FINISH;
            end
         end
         ST_SHIFT1: begin
            if (r_cnt1 == 2'd1) w_next_state = ST_FINISH;
         end
         ST_FINISH: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Operand capture and per-step accumulator/counter updates
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc  <= '0;
         r_cnt4 <= '0;
         r_cnt1 <= '0;
         r_dir  <= 1'b0;
         r_fill <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_capture) begin
                  r_acc  <= s_if.data_in;
                  r_cnt4 <= w_amt4;
                  r_cnt1 <= w_amt1;
                  r_dir  <= s_if.dir;
                  r_fill <= s_if.arith & s_if.dir & s_if.data_in[WIDTH-1];
               end
            end
            ST_SHIFT4: begin
               r_acc  <= i_stg_out;
               r_cnt4 <= r_cnt4 - CNT4_W'(1);
            end
            ST_SHIFT1: begin
               r_acc  <= w_shift1;
               r_cnt1 <= r_cnt1 - 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

   // Registered completion: RESULT updates only together with the DONE pulse
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_result <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= (r_state == ST_FINISH);
         if (r_state == ST_FINISH) r_result <= r_acc;
      end
   end

   assign s_if.busy   = (r_state != ST_IDLE) || r_done;
   assign s_if.done   = r_done;
   assign s_if.result = r_result;

   // Stage controls: direction and fill hold from capture to capture; the
   // stage only shifts while in SHIFT4 and passes through otherwise.
   assign o_stg_sh_dir = r_dir;
   assign o_stg_neg    = r_fill;
   assign o_stg_amt_n  = (r_state == ST_SHIFT4);
   assign o_stg_in     = r_acc;

endmodule
